// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type codes, FSM encoding and bus layouts for the MEM stage.
package mem_stage_pkg;

    localparam int unsigned EX_TO_MEM_WD = 79;
    localparam int unsigned MEM_TO_WB_WD = 70;
    localparam int unsigned MEM_TO_ID_WD = 38;
    localparam int unsigned LD_TYPE_WD   = 3;

    localparam logic [LD_TYPE_WD-1:0] LD_LW  = 3'd0;
    localparam logic [LD_TYPE_WD-1:0] LD_LB  = 3'd1;
    localparam logic [LD_TYPE_WD-1:0] LD_LBU = 3'd2;
    localparam logic [LD_TYPE_WD-1:0] LD_LH  = 3'd3;
    localparam logic [LD_TYPE_WD-1:0] LD_LHU = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [LD_TYPE_WD-1:0] ld_type;
        logic [31:0]           pc;
        logic                  data_ram_en;
        logic [3:0]            data_ram_wen;
        logic                  sel_rf_res;
        logic                  rf_we;
        logic [4:0]            rf_waddr;
        logic [31:0]           ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_id_t;

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [LD_TYPE_WD-1:0] ld_type,
    input  logic [1:0]            addr,
    input  logic [31:0]           rdata,
    output logic [31:0]           data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        // Halfword loads ignore addr[0]; misalignment is not trapped here.
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (ld_type)
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {24'h0, byte_sel};
            LD_LH:   data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, waits for the SRAM read response,
// aligns load data and drives the WB and ID forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_rvalid,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    stallreq_for_mem
);

    ex_to_mem_t bus_r;
    mem_state_e state;
    mem_state_e state_nxt;
    logic [31:0] rbuf;
    logic [31:0] rbuf_nxt;
    logic [31:0] load_word;
    logic [31:0] load_aligned;
    logic [31:0] rf_wdata;
    logic        is_load;
    logic        stallreq;
    mem_to_wb_t  wb;
    mem_to_id_t  fwd;

    logic unused_stall;
    assign unused_stall = &{1'b0, stall[5], stall[2:0]};

    // Input register: bubble when MEM stalls but WB moves on, hold when both stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_r <= '0;
        end else if (stall[3] && !stall[4]) begin
            bus_r <= '0;
        end else if (!stall[3]) begin
            bus_r <= ex_to_mem_t'(ex_to_mem_bus);
        end
    end

    assign is_load = bus_r.data_ram_en && (bus_r.data_ram_wen == 4'h0) && bus_r.sel_rf_res;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            rbuf  <= 32'h0;
        end else begin
            state <= state_nxt;
            rbuf  <= rbuf_nxt;
        end
    end

    // Response tracking: WAIT until rvalid, HOLD the captured word while the stage is frozen.
    always_comb begin
        state_nxt = state;
        rbuf_nxt  = rbuf;
        stallreq  = 1'b0;
        load_word = data_sram_rdata;
        case (state)
            IDLE: begin
                if (is_load) begin
                    if (!data_sram_rvalid) begin
                        stallreq  = 1'b1;
                        state_nxt = WAIT;
                    end else if (stall[3]) begin
                        rbuf_nxt  = data_sram_rdata;
                        state_nxt = HOLD;
                    end
                end
            end
            WAIT: begin
                if (!data_sram_rvalid) begin
                    stallreq = 1'b1;
                end else begin
                    rbuf_nxt  = data_sram_rdata;
                    state_nxt = stall[3] ? HOLD : IDLE;
                end
            end
            HOLD: begin
                load_word = rbuf;
                if (!stall[3]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    mem_load_align u_align (
        .ld_type (bus_r.ld_type),
        .addr    (bus_r.ex_result[1:0]),
        .rdata   (load_word),
        .data    (load_aligned)
    );

    assign rf_wdata = is_load ? load_aligned : bus_r.ex_result;

    // An unready load must never be forwarded to ID.
    always_comb begin
        wb.pc        = bus_r.pc;
        wb.rf_we     = bus_r.rf_we;
        wb.rf_waddr  = bus_r.rf_waddr;
        wb.rf_wdata  = rf_wdata;
        fwd.rf_we    = bus_r.rf_we && !stallreq;
        fwd.rf_waddr = bus_r.rf_waddr;
        fwd.rf_wdata = rf_wdata;
    end

    assign mem_to_wb_bus    = wb;
    assign mem_to_id_bus    = fwd;
    assign stallreq_for_mem = stallreq;

endmodule
